// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: bitwise logic unit with valid/ready input, DEPTH-entry
// output FIFO, saturating accept counter and a sticky reserved-mode flag.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count,
  output logic             illegal_mode,
  input  logic             clr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             ready_en;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] result;

  // in_ready only rises on the first edge after reset release.
  assign in_ready  = ready_en && (occ < FULL_CNT);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign output_   = out_valid ? mem[rd_ptr] : '0;
  assign out_zero  = out_valid && (output_ == '0);

  // Operation select; reserved mode yields zero.
  always_comb begin
    result = '0;
    case (mode)
      3'b000:  result = input_a & input_b;
      3'b001:  result = input_a | input_b;
      3'b010:  result = input_a ^ input_b;
      3'b011:  result = ~(input_a & input_b);
      3'b100:  result = ~(input_a | input_b);
      3'b101:  result = ~(input_a ^ input_b);
      3'b110:  result = input_a & ~input_b;
      default: result = '0;
    endcase
  end

  // FIFO storage write at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= result;
    end
  end

  // Pointers, occupancy and post-reset ready enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        occ <= occ + 1'b1;
      end else if (pop && !push) begin
        occ <= occ - 1'b1;
      end
    end
  end

  // Saturating accept counter and sticky reserved-mode flag; clr wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count     <= '0;
      illegal_mode <= 1'b0;
    end else if (clr) begin
      op_count     <= '0;
      illegal_mode <= 1'b0;
    end else if (push) begin
      if (op_count != '1) begin
        op_count <= op_count + 1'b1;
      end
      if (mode == 3'b111) begin
        illegal_mode <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed testbench for logic_unit_pipe.
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero, illegal_mode, clr;
  logic [7:0]  input_a, input_b, output_;
  logic [2:0]  mode;
  logic [15:0] op_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero, b_illegal, b_clr;
  logic [7:0]  b_a, b_b, b_out;
  logic [2:0]  b_mode;
  logic [2:0]  b_count;

  int unsigned checks;
  int unsigned failures;

  logic [7:0] sweep_exp [7];

  logic_unit_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .input_a(input_a), .input_b(input_b), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .output_(output_),
    .out_zero(out_zero), .op_count(op_count), .illegal_mode(illegal_mode),
    .clr(clr)
  );

  logic_unit_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .input_a(b_a), .input_b(b_b), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .output_(b_out),
    .out_zero(b_out_zero), .op_count(b_count), .illegal_mode(b_illegal),
    .clr(b_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    sweep_exp[0] = 8'h4A; sweep_exp[1] = 8'hDF; sweep_exp[2] = 8'h95;
    sweep_exp[3] = 8'hB5; sweep_exp[4] = 8'h20; sweep_exp[5] = 8'h6A;
    sweep_exp[6] = 8'h80;
    rst = 1'b0; clr = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; input_a = '0; input_b = '0; mode = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_a = '0; b_b = '0; b_mode = '0; b_clr = 1'b0;

    // reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_output", output_, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_op_count", op_count, 0);
    check("rst_illegal", illegal_mode, 0);
    check("rst_in_ready", in_ready, 0);
    #20 rst = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // single op
    in_valid = 1'b1; input_a = 8'hF0; input_b = 8'h3C; mode = 3'b000; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_out", output_, 8'h30);
    check("single_zero", out_zero, 0);
    check("single_count", op_count, 1);
    tick();
    check("single_drained", out_valid, 0);

    // clear counter, then mode sweep
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_count", op_count, 0);
    for (int unsigned i = 0; i < 7; i++) begin
      in_valid = 1'b1; input_a = 8'hCA; input_b = 8'h5F; mode = 3'(i);
      tick();
      check($sformatf("sweep_valid%0d", i), out_valid, 1);
      check($sformatf("sweep_out%0d", i), output_, sweep_exp[i]);
    end
    in_valid = 1'b0;
    check("sweep_count", op_count, 7);
    tick();
    check("sweep_drained", out_valid, 0);

    // backpressure / full
    out_ready = 1'b0;
    in_valid = 1'b1; input_a = 8'h01; input_b = 8'h01; mode = 3'b000;
    tick();
    check("bp_ready_after1", in_ready, 1);
    input_a = 8'h02; input_b = 8'h00; mode = 3'b001;
    tick();
    check("bp_full_ready", in_ready, 0);
    check("bp_head", output_, 8'h01);
    input_a = 8'hFF; input_b = 8'hFF; mode = 3'b001;
    tick();
    in_valid = 1'b0;
    check("bp_ignored_count", op_count, 9);
    check("bp_still_full", in_ready, 0);
    check("bp_head_hold", output_, 8'h01);
    out_ready = 1'b1;
    tick();
    check("bp_pop1", output_, 8'h02);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_empty", out_valid, 0);
    check("bp_empty_out", output_, 0);

    // streaming at occupancy 1
    for (int unsigned i = 0; i < 20; i++) begin
      in_valid = 1'b1; input_a = 8'(i); input_b = 8'h55; mode = 3'b010;
      tick();
      check($sformatf("stream_valid%0d", i), out_valid, 1);
      check($sformatf("stream_out%0d", i), output_, 8'(i) ^ 8'h55);
      check($sformatf("stream_ready%0d", i), in_ready, 1);
    end
    in_valid = 1'b0;
    check("stream_count", op_count, 29);
    tick();
    check("stream_drained", out_valid, 0);

    // reserved mode and clr with simultaneous accept
    out_ready = 1'b0;
    in_valid = 1'b1; input_a = 8'hFF; input_b = 8'hFF; mode = 3'b111;
    tick();
    check("resv_valid", out_valid, 1);
    check("resv_out", output_, 0);
    check("resv_zero", out_zero, 1);
    check("resv_illegal", illegal_mode, 1);
    clr = 1'b1; input_a = 8'h0F; input_b = 8'hF0; mode = 3'b001;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_acc_count", op_count, 0);
    check("clr_acc_illegal", illegal_mode, 0);
    check("clr_acc_head", output_, 0);
    check("clr_acc_full", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("clr_acc_pop", output_, 8'hFF);
    check("clr_acc_nz", out_zero, 0);
    tick();
    check("clr_acc_empty", out_valid, 0);
    out_ready = 1'b0;

    // saturation on CNT_W=3 instance
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_a = 8'hFF; b_b = 8'h0F; b_mode = 3'b000;
    for (int unsigned i = 0; i < 9; i++) begin
      tick();
    end
    b_in_valid = 1'b0;
    check("sat_count", b_count, 7);
    check("sat_out", b_out, 8'h0F);
    tick();
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_a = 8'hAA; b_b = 8'hFF;
    tick();
    tick();
    b_in_valid = 1'b0;
    check("sat_hold", b_count, 7);
    check("sat_buffered", b_out_valid, 1);
    check("sat_full", b_in_ready, 0);

    // asynchronous reset mid-stream
    #2 rst = 1'b0;
    #1;
    check("arst_valid", b_out_valid, 0);
    check("arst_out", b_out, 0);
    check("arst_count", b_count, 0);
    check("arst_ready", b_in_ready, 0);
    #2 rst = 1'b1;
    tick();
    check("arst_ready_back", b_in_ready, 1);
    check("arst_discarded", b_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
